// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - md_op encodings and default cycle counts for the multiply/divide unit
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit with HI/LO registers and a busy interlock
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYC,
  parameter int DIV_CYCLES  = MD_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state, state_next;
  md_op_e      op;
  logic [3:0]  cnt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_skip;

  logic        is_start;
  logic [3:0]  load_cnt;
  logic [31:0] res_hi, res_lo;
  logic        res_skip;

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, quo_s, rem_s, quo_u, rem_u;
  logic        div_ovf;

  assign op = md_op_e'(md_op);

  // b_safe keeps the dividers X-free on divide-by-zero; that result is never committed anyway.
  assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u  = {32'b0, a} * {32'b0, b};
  assign b_safe  = (b == 32'd0) ? 32'd1 : b;
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign quo_s   = $signed(a) / $signed(b_safe);
  assign rem_s   = $signed(a) % $signed(b_safe);
  assign quo_u   = a / b_safe;
  assign rem_u   = a % b_safe;

  always_comb begin
    is_start = 1'b0;
    load_cnt = 4'd0;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_skip = 1'b0;
    case (op)
      MD_MULT: begin
        is_start         = 1'b1;
        load_cnt         = MULT_LOAD;
        {res_hi, res_lo} = prod_s;
      end
      MD_MULTU: begin
        is_start         = 1'b1;
        load_cnt         = MULT_LOAD;
        {res_hi, res_lo} = prod_u;
      end
      MD_DIV: begin
        is_start = 1'b1;
        load_cnt = DIV_LOAD;
        res_skip = (b == 32'd0);
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MD_DIVU: begin
        is_start = 1'b1;
        load_cnt = DIV_LOAD;
        res_skip = (b == 32'd0);
        res_hi   = rem_u;
        res_lo   = quo_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (is_start) state_next = ST_RUN;
      ST_RUN:  if (cnt == 4'd0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_skip <= 1'b0;
      cnt       <= 4'd0;
    end else if (state == ST_IDLE) begin
      if (is_start) begin
        pend_hi   <= res_hi;
        pend_lo   <= res_lo;
        pend_skip <= res_skip;
        cnt       <= load_cnt;
      end else if (op == MD_MTHI) begin
        hi <= a;
      end else if (op == MD_MTLO) begin
        lo <= a;
      end
    end else begin
      // md_op is deliberately ignored while running; only the countdown advances.
      if (cnt == 4'd0) begin
        if (!pend_skip) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit with HI/LO registers, sitting in the E stage of the 5-stage MIPS pipeline, beside the ALU.
- Executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes.
- Exposes busy to the hazard/stall unit, which holds any md-class instruction in D while busy is high or an md start is issued in E.
- HI/LO values feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- md_op  input  3  operation from E-stage decode; encoding in the shared header.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- busy  output  1  operation in flight; HI/LO not yet final.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result cleared. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE (busy=0), RUN (busy=1). Counter is 4 bits wide and loaded with the cycle count.
- IDLE, md_op in {MULT,MULTU,DIV,DIVU} at edge k:
  - Operands sampled and the 64-bit result computed into pending_hi/pending_lo at edge k.
  - Counter loaded with N-1, where N is MULT_CYCLES or DIV_CYCLES; state enters RUN.
  - busy is high for cycles k+1 .. k+N.
- RUN: counter decrements each edge. At the edge where counter==0, hi<=pending_hi, lo<=pending_lo and state returns to IDLE. New values are visible and busy=0 in cycle k+N+1.
- IDLE, md_op==MTHI: hi<=a at that edge, lo unchanged, busy stays 0. MTLO: lo<=a, hi unchanged.
- md_op==NONE or an unused code: no state change.
- Any md_op other than NONE while in RUN is ignored, and hi, lo and the counter are unaffected. The stall unit guarantees this never occurs; the bench flags it as a protocol violation.
- Arithmetic:
  - mult: {hi,lo} = signed(a)*signed(b), full 64 bits.
  - multu: unsigned 64-bit product.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Division by zero (b==0): the full DIV_CYCLES busy period still runs, but hi/lo are left unchanged at completion.
- hi/lo outputs are pure register outputs with no bypass. mfhi/mflo in E read the registers directly.

Decomposition:
- Shared header (the team's existing macro header) gains:
  - md_op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default cycle counts MD_MULT_CYC=5, MD_DIV_CYC=10.
- The stall unit's decode adds an md-class group (mult/div/mfhi/mthi) that stalls in D when busy is high or E's md_op is a start code.
- No sub-module. Datapath and FSM are one module; the arithmetic uses the synthesiser's * / % operators inside the start branch.

Test Plan:
- Reset, then mult a=0xFFFFFFFF b=2 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; divu a=7 b=2 -> lo=3 hi=1.
- mthi a=0x1234 then mtlo a=0x5678 in consecutive cycles -> hi=0x1234, lo=0x5678, busy never asserted; then div b=0 -> busy 10 cycles, hi/lo stay 0x1234/0x5678.
- Start mult, then present md_op=DIV and MTHI on cycles 2-3 of busy -> ignored; final hi/lo are the mult result, and busy drops after exactly 5 cycles.
- Start div, drop reset low in busy cycle 4 -> busy=0 and hi=lo=0 immediately; after release a new mult completes normally.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0, with no X on any output.
